// File: rtl/alu_wb_param_if.sv
// Wishbone pipelined single-beat bus bundle for alu_wb_param.
// Ports: stb/we/addr/data requests in, ack/stall/data/busy out.
interface alu_wb_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              i_wb_stb;
    logic              i_wb_we;
    logic [ADDR_W-1:0] i_wb_addr;
    logic [DATA_W-1:0] i_wb_data;
    logic              o_wb_ack;
    logic              o_wb_stall;
    logic [DATA_W-1:0] o_wb_data;
    logic              o_busy;

    modport slave (
        input  i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_ack, o_wb_stall, o_wb_data, o_busy
    );

    modport master (
        output i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_ack, o_wb_stall, o_wb_data, o_busy
    );
endinterface

// File: rtl/alu_wb_param.sv
// Wishbone ALU peripheral: A/B operands, OP launches, OUT/OUT_HI/FLAGS.
// Ports: i_clk, reset (async high), bus (slave). ALU_WB_MUL_EN adds MUL.
module alu_wb_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic           i_clk,
    input  logic           reset,
    alu_wb_param_if.slave  bus
);
    logic [DATA_W-1:0] a, b, op, out, rdata;
    logic              fn, fv, fz, fc;
    logic              ack, busy, accept;
    logic [DATA_W-1:0] out_hi;
    logic [3:0]        opc;

    assign accept = bus.i_wb_stb & ~busy;
    assign opc    = bus.i_wb_data[3:0];

    assign bus.o_wb_ack   = ack;
    assign bus.o_wb_stall = busy;
    assign bus.o_wb_data  = rdata;
    assign bus.o_busy     = busy;

    logic [7:0]        flags8;
    logic [DATA_W-1:0] rd_val;
    assign flags8 = {fn, fv, 4'b0000, fz, fc};

    always_comb begin
        rd_val = '0;
        case (bus.i_wb_addr)
            ADDR_W'(0): rd_val = a;
            ADDR_W'(1): rd_val = b;
            ADDR_W'(2): rd_val = op;
            ADDR_W'(3): rd_val = out;
            ADDR_W'(4): rd_val = DATA_W'(flags8);
            ADDR_W'(5): rd_val = out_hi;
            ADDR_W'(6): rd_val = DATA_W'(busy);
            default:    rd_val = '0;
        endcase
    end

    // Arithmetic in DATA_W+1 bits; the top bit is the carry.
    logic [DATA_W:0] add_s, sub_s, cmp_s;
    assign add_s = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, fc};
    assign sub_s = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, fc};
    assign cmp_s = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};

    localparam int M = DATA_W - 1;

    logic [DATA_W-1:0] nx_out;
    logic nx_n, nx_v, nx_z, nx_c, op_hit, wr_nz;

    always_comb begin
        nx_out = out;
        nx_n   = fn;
        nx_v   = fv;
        nx_z   = fz;
        nx_c   = fc;
        op_hit = 1'b1;
        wr_nz  = 1'b1;
        case (opc)
            4'h0: begin
                nx_out = add_s[M:0];
                nx_c   = add_s[DATA_W];
                nx_v   = (a[M] == b[M]) & (add_s[M] != a[M]);
            end
            4'h1: begin
                nx_out = sub_s[M:0];
                nx_c   = sub_s[DATA_W];
                nx_v   = (a[M] != b[M]) & (sub_s[M] != a[M]);
            end
            4'h2: nx_out = a & b;
            4'h3: nx_out = a | b;
            4'h4: nx_out = a ^ b;
            4'h5: begin
                nx_out = {a[M-1:0], 1'b0};
                nx_c   = a[M];
            end
            4'h6: begin
                nx_out = {1'b0, a[M:1]};
                nx_c   = a[0];
            end
            4'h7: begin
                nx_out = {a[M-1:0], fc};
                nx_c   = a[M];
            end
            4'h8: begin
                nx_out = {fc, a[M:1]};
                nx_c   = a[0];
            end
            4'h9: begin
                wr_nz = 1'b0;
                nx_n  = cmp_s[M];
                nx_z  = (cmp_s[M:0] == '0);
                nx_c  = cmp_s[DATA_W];
            end
            4'hA: nx_out = a + 1'b1;
            4'hB: nx_out = a - 1'b1;
            default: begin
                op_hit = 1'b0;
                wr_nz  = 1'b0;
            end
        endcase
        if (wr_nz) begin
            nx_n = nx_out[M];
            nx_z = (nx_out == '0);
        end
    end

`ifdef ALU_WB_MUL_EN
    localparam int CW = $clog2(DATA_W);
    logic [2*DATA_W-1:0] mcand, acc, acc_nx;
    logic [DATA_W-1:0]   mplr;
    logic [CW-1:0]       cnt;
    logic                busy_q;

    assign busy   = busy_q;
    assign acc_nx = acc + (mplr[0] ? mcand : '0);
`else
    assign busy   = 1'b0;
    assign out_hi = '0;
`endif

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            a     <= '0;
            b     <= '0;
            op    <= '0;
            out   <= '0;
            rdata <= '0;
            ack   <= 1'b0;
            fn    <= 1'b0;
            fv    <= 1'b0;
            fz    <= 1'b0;
            fc    <= 1'b0;
`ifdef ALU_WB_MUL_EN
            out_hi <= '0;
            busy_q <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplr   <= '0;
            acc    <= '0;
`endif
        end else begin
            ack <= accept;
            if (accept && !bus.i_wb_we)
                rdata <= rd_val;
            if (accept && bus.i_wb_we) begin
                case (bus.i_wb_addr)
                    ADDR_W'(0): a <= bus.i_wb_data;
                    ADDR_W'(1): b <= bus.i_wb_data;
                    ADDR_W'(2): begin
                        op <= bus.i_wb_data;
                        if (op_hit) begin
                            out <= nx_out;
                            fn  <= nx_n;
                            fv  <= nx_v;
                            fz  <= nx_z;
                            fc  <= nx_c;
`ifdef ALU_WB_MUL_EN
                            out_hi <= '0;
`endif
                        end
`ifdef ALU_WB_MUL_EN
                        if (opc == 4'hC) begin
                            busy_q <= 1'b1;
                            cnt    <= '0;
                            mcand  <= {{DATA_W{1'b0}}, a};
                            mplr   <= b;
                            acc    <= '0;
                        end
`endif
                    end
                    ADDR_W'(4): begin
                        fn <= bus.i_wb_data[7];
                        fv <= bus.i_wb_data[6];
                        fz <= bus.i_wb_data[1];
                        fc <= bus.i_wb_data[0];
                    end
                    default: ;
                endcase
            end
`ifdef ALU_WB_MUL_EN
            // One multiplier bit per cycle; last step commits the product.
            if (busy_q) begin
                acc   <= acc_nx;
                mcand <= mcand << 1;
                mplr  <= mplr >> 1;
                cnt   <= cnt + 1'b1;
                if (cnt == CW'(DATA_W - 1)) begin
                    busy_q <= 1'b0;
                    cnt    <= '0;
                    out    <= acc_nx[DATA_W-1:0];
                    out_hi <= acc_nx[2*DATA_W-1:DATA_W];
                    fz     <= (acc_nx == '0);
                    fn     <= acc_nx[2*DATA_W-1];
                    fc     <= 1'b0;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_wb_param.sv
// Self-checking bench for alu_wb_param with a read-data scoreboard.
// Define ALU_WB_MUL_EN for both RTL and bench to exercise the multiplier.
module tb_alu_wb_param;
    logic i_clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    alu_wb_param_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    alu_wb_param #(.DATA_W(8), .ADDR_W(4)) dut (
        .i_clk (i_clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit         rd;
        logic [7:0] exp;
        string      tag;
    } sb_t;
    sb_t sb[$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (!reset && bus.o_wb_ack) begin
            if (sb.size() == 0) begin
                check("spurious_ack", bus.o_wb_ack, 1'b0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                if (e.rd)
                    check(e.tag, bus.o_wb_data, e.exp);
            end
        end
    end

    // Called and returns at a negedge; waits out stall, then one-cycle beat.
    task automatic xfer(bit we, logic [3:0] addr, logic [7:0] data,
                        logic [7:0] exp, string tag, output int waits);
        sb_t e;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = we;
        bus.i_wb_addr = addr;
        bus.i_wb_data = data;
        waits = 0;
        while (bus.o_wb_stall && waits < 200) begin
            @(negedge i_clk);
            waits++;
        end
        if (waits >= 200)
            check("stall_timeout", bus.o_wb_stall, 1'b0);
        e.rd  = !we;
        e.exp = exp;
        e.tag = tag;
        sb.push_back(e);
        @(posedge i_clk);
        @(negedge i_clk);
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
        check({tag, "_ack"}, bus.o_wb_ack, 1'b1);
    endtask

    task automatic wr(logic [3:0] addr, logic [7:0] data);
        int w;
        xfer(1'b1, addr, data, 8'h00, "wr", w);
    endtask

    task automatic rd(logic [3:0] addr, logic [7:0] exp, string tag);
        int w;
        xfer(1'b0, addr, 8'h00, exp, tag, w);
    endtask

    task automatic reset_checks(string tag);
        #1;
        check({tag, "_ack"}, bus.o_wb_ack, 1'b0);
        check({tag, "_stall"}, bus.o_wb_stall, 1'b0);
        check({tag, "_busy"}, bus.o_busy, 1'b0);
    endtask

    initial begin
        int w;
        int n;
        bus.i_wb_stb  = 1'b0;
        bus.i_wb_we   = 1'b0;
        bus.i_wb_addr = '0;
        bus.i_wb_data = '0;
        repeat (2) @(negedge i_clk);
        reset = 1'b0;
        @(negedge i_clk);

        wr(4'd0, 8'h33);
        wr(4'd1, 8'h44);
        wr(4'd4, 8'hC3);
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = 1'b1;
        bus.i_wb_addr = 4'd2;
        bus.i_wb_data = 8'h00;
        @(posedge i_clk);
        #1 reset = 1'b1;
        bus.i_wb_stb = 1'b0;
        reset_checks("rst_mid");
        @(negedge i_clk);
        reset = 1'b0;
        for (int i = 0; i <= 6; i++)
            rd(4'(i), 8'h00, $sformatf("rst_rd%0d", i));

        wr(4'd0, 8'h7F);
        wr(4'd1, 8'h01);
        wr(4'd4, 8'h00);
        wr(4'd2, 8'h00);
        rd(4'd3, 8'h80, "adc_out");
        rd(4'd4, 8'hC0, "adc_flags");
        rd(4'd2, 8'h00, "op_rb");

        wr(4'd0, 8'hFF);
        wr(4'd1, 8'h01);
        wr(4'd2, 8'h00);
        rd(4'd3, 8'h00, "wrap_out");
        rd(4'd4, 8'h03, "wrap_flags");
        wr(4'd0, 8'h00);
        wr(4'd1, 8'h00);
        wr(4'd2, 8'h00);
        rd(4'd3, 8'h01, "chain_out");
        rd(4'd4, 8'h00, "chain_flags");

        wr(4'd0, 8'h10);
        wr(4'd1, 8'h20);
        wr(4'd2, 8'h09);
        rd(4'd3, 8'h01, "cmp_out");
        rd(4'd4, 8'h80, "cmp_flags");
        wr(4'd0, 8'h81);
        wr(4'd4, 8'h01);
        wr(4'd2, 8'h08);
        rd(4'd3, 8'hC0, "ror_out");
        rd(4'd4, 8'h81, "ror_flags");
        wr(4'd2, 8'h05);
        rd(4'd3, 8'h02, "asl_out");
        rd(4'd4, 8'h01, "asl_flags");

        wr(4'd0, 8'hFF);
        wr(4'd4, 8'h00);
        wr(4'd2, 8'h0A);
        rd(4'd3, 8'h00, "inc_out");
        rd(4'd4, 8'h02, "inc_flags");
        wr(4'd0, 8'h00);
        wr(4'd2, 8'h0B);
        rd(4'd3, 8'hFF, "dec_out");
        rd(4'd4, 8'h80, "dec_flags");

        wr(4'd4, 8'hFF);
        rd(4'd4, 8'hC3, "flag_mask");
        wr(4'd3, 8'h55);
        wr(4'd9, 8'h55);
        rd(4'd3, 8'hFF, "ro_out");
        rd(4'd9, 8'h00, "undec_rd");

`ifdef ALU_WB_MUL_EN
        wr(4'd0, 8'hFF);
        wr(4'd1, 8'hFF);
        wr(4'd4, 8'h00);
        wr(4'd2, 8'h0C);
        n = 0;
        while (bus.o_busy && n < 100) begin
            n++;
            @(negedge i_clk);
        end
        check("mul_busy_len", n, 8);
        rd(4'd3, 8'h01, "mul_lo");
        rd(4'd5, 8'hFE, "mul_hi");
        rd(4'd4, 8'h80, "mul_flags");
        wr(4'd2, 8'h0C);
        xfer(1'b0, 4'd6, 8'h00, 8'h00, "mul_status", w);
        check("mul_stall_len", w, 8);
        rd(4'd3, 8'h01, "mul2_lo");

        wr(4'd2, 8'h0C);
        repeat (2) @(negedge i_clk);
        check("mul_abort_pre", bus.o_busy, 1'b1);
        reset = 1'b1;
        reset_checks("mul_abort");
        @(negedge i_clk);
        reset = 1'b0;
        repeat (10) @(negedge i_clk);
        rd(4'd3, 8'h00, "abort_out");
        rd(4'd5, 8'h00, "abort_hi");
        rd(4'd0, 8'h00, "abort_a");
        rd(4'd6, 8'h00, "abort_status");
`else
        wr(4'd0, 8'h05);
        wr(4'd1, 8'h03);
        wr(4'd4, 8'h00);
        wr(4'd2, 8'h00);
        wr(4'd4, 8'hC3);
        wr(4'd2, 8'h0C);
        check("nomul_busy", bus.o_busy, 1'b0);
        check("nomul_stall", bus.o_wb_stall, 1'b0);
        rd(4'd3, 8'h08, "nomul_out");
        rd(4'd4, 8'hC3, "nomul_flags");
        rd(4'd5, 8'h00, "nomul_hi");
        rd(4'd6, 8'h00, "nomul_status");
        rd(4'd2, 8'h0C, "nomul_op");
`endif

        repeat (3) @(negedge i_clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
